// File: rtl/hp2vga_pkg.sv
// Shared definitions for the HP-to-VGA capture path: lock states, default
// raster timing and the decoder sample width.
package hp2vga_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      HLOCK    = 2'd1,
      CAPTURE  = 2'd2
   } capture_state_t;

   localparam int H_TOTAL_DEF  = 800;
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 400;
   localparam int TVP_W        = 10;

   function automatic logic period_in_tol(input int period, input int nominal, input int tol);
      return (period >= nominal - tol) && (period <= nominal + tol);
   endfunction

endpackage

// File: rtl/sync_period_monitor.sv
// Sync edge detection and line-period measurement for the TVP capture front end.
// Reports HSYNC/VSYNC falls, the pixel position x_cnt and per-line period verdicts.
module sync_period_monitor
   import hp2vga_pkg::*;
#(
   parameter int H_TOTAL = H_TOTAL_DEF,
   parameter int H_TOL   = 2,
   parameter int X_W     = $clog2(2 * H_TOTAL)
) (
   input  logic           TVP_CLK,
   input  logic           RESET_N,
   input  logic           hs,
   input  logic           vs,
   output logic           hs_fall,
   output logic           vs_fall,
   output logic [X_W-1:0] x_cnt,
   output logic           period_ok,
   output logic           period_bad,
   output logic [1:0]     good_cnt
);

   localparam int X_MAX = 2 * H_TOTAL - 1;

   logic hs_prev;
   logic vs_prev;
   logic armed;
   logic timeout;
   logic good_now;

   assign hs_fall = hs_prev & ~hs;
   assign vs_fall = vs_prev & ~vs;

   // The first HSYNC fall after reset or a timeout has no valid start point, so it only arms the check.
   assign timeout    = ~hs_fall & (x_cnt == X_W'(X_MAX - 1));
   assign good_now   = period_in_tol(int'(x_cnt) + 1, H_TOTAL, H_TOL);
   assign period_ok  = hs_fall & armed & good_now;
   assign period_bad = (hs_fall & armed & ~good_now) | timeout;

   always_ff @(posedge TVP_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hs_prev  <= 1'b1;
         vs_prev  <= 1'b1;
         x_cnt    <= '0;
         armed    <= 1'b0;
         good_cnt <= 2'd0;
      end else begin
         hs_prev <= hs;
         vs_prev <= vs;

         if (hs_fall) begin
            x_cnt <= '0;
         end else if (x_cnt != X_W'(X_MAX)) begin
            x_cnt <= x_cnt + 1'b1;
         end

         if (timeout) begin
            armed    <= 1'b0;
            good_cnt <= 2'd0;
         end else if (hs_fall) begin
            armed <= 1'b1;
            if (armed && good_now) begin
               if (good_cnt != 2'd2) begin
                  good_cnt <= good_cnt + 2'd1;
               end
            end else begin
               good_cnt <= 2'd0;
            end
         end
      end
   end

endmodule

// File: rtl/tvp_pixel_capture.sv
// TVP decoder front end: locks to the sync timing, windows the active picture,
// thresholds luma to 1 bit and writes packed 8-pixel words to the frame buffer.
module tvp_pixel_capture
   import hp2vga_pkg::*;
#(
   parameter int               H_TOTAL   = H_TOTAL_DEF,
   parameter int               H_TOL     = 2,
   parameter int               H_START   = 96,
   parameter int               H_ACTIVE  = H_ACTIVE_DEF,
   parameter int               V_START   = 35,
   parameter int               V_ACTIVE  = V_ACTIVE_DEF,
   parameter logic [TVP_W-1:0] THRESHOLD = 10'd512,
   parameter int               ADDR_W    = 15
) (
   input  logic              TVP_CLK,
   input  logic              RESET_N,
   input  logic              TVP_HSYNC,
   input  logic              TVP_VSYNC,
   input  logic [TVP_W-1:0]  TVP_VIDEO,
   output logic              WR_EN,
   output logic [ADDR_W-1:0] WR_ADDR,
   output logic [7:0]        WR_DATA,
   output logic              FRAME_START,
   output logic              LOCKED,
   output logic              LINE_ERR
);

   localparam int X_W       = $clog2(2 * H_TOTAL);
   localparam int Y_W       = 11;
   localparam int LAST_ADDR = H_ACTIVE / 8 * V_ACTIVE - 1;

   capture_state_t state;

   logic              hs_q;
   logic              vs_q;
   logic [TVP_W-1:0]  video_q;
   logic              hs_fall;
   logic              vs_fall;
   logic [X_W-1:0]    x_cnt;
   logic [Y_W-1:0]    y_cnt;
   logic              period_ok;
   logic              period_bad;
   logic [1:0]        good_cnt;
   logic              in_window;
   logic              pix_bit;
   logic              frame_restart;
   logic [7:0]        sreg;
   logic [2:0]        phase;
   logic              word_done;
   logic [ADDR_W-1:0] addr;
   logic              addr_full;

   always_ff @(posedge TVP_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         video_q <= '0;
      end else begin
         hs_q    <= TVP_HSYNC;
         vs_q    <= TVP_VSYNC;
         video_q <= TVP_VIDEO;
      end
   end

   sync_period_monitor #(
      .H_TOTAL (H_TOTAL),
      .H_TOL   (H_TOL),
      .X_W     (X_W)
   ) u_monitor (
      .TVP_CLK    (TVP_CLK),
      .RESET_N    (RESET_N),
      .hs         (hs_q),
      .vs         (vs_q),
      .hs_fall    (hs_fall),
      .vs_fall    (vs_fall),
      .x_cnt      (x_cnt),
      .period_ok  (period_ok),
      .period_bad (period_bad),
      .good_cnt   (good_cnt)
   );

   // A VSYNC fall landing on an HSYNC fall still restarts the frame at line 0.
   always_ff @(posedge TVP_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         y_cnt <= '0;
      end else if (vs_fall) begin
         y_cnt <= '0;
      end else if (hs_fall && (y_cnt != '1)) begin
         y_cnt <= y_cnt + 1'b1;
      end
   end

   always_ff @(posedge TVP_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= UNLOCKED;
         FRAME_START <= 1'b0;
         LOCKED      <= 1'b0;
         LINE_ERR    <= 1'b0;
      end else begin
         FRAME_START <= 1'b0;
         LINE_ERR    <= period_bad;
         case (state)
            UNLOCKED: begin
               if (period_ok && (good_cnt != 2'd0)) begin
                  state <= HLOCK;
               end
            end
            HLOCK: begin
               if (period_bad) begin
                  state <= UNLOCKED;
               end else if (vs_fall) begin
                  state       <= CAPTURE;
                  LOCKED      <= 1'b1;
                  FRAME_START <= 1'b1;
               end
            end
            CAPTURE: begin
               if (period_bad) begin
                  state  <= UNLOCKED;
                  LOCKED <= 1'b0;
               end else if (vs_fall) begin
                  FRAME_START <= 1'b1;
               end
            end
            default: begin
               state  <= UNLOCKED;
               LOCKED <= 1'b0;
            end
         endcase
      end
   end

   assign frame_restart = vs_fall && !period_bad && (state != UNLOCKED);
   assign pix_bit       = (video_q >= THRESHOLD);
   assign in_window     = (state == CAPTURE)
                          && (int'(x_cnt) >= H_START) && (int'(x_cnt) < H_START + H_ACTIVE)
                          && (int'(y_cnt) >= V_START) && (int'(y_cnt) < V_START + V_ACTIVE);

   // A completed word is written the cycle after its 8th pixel; losing sync kills it.
   always_ff @(posedge TVP_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sreg      <= '0;
         phase     <= '0;
         word_done <= 1'b0;
         addr      <= '0;
         addr_full <= 1'b0;
         WR_EN     <= 1'b0;
         WR_ADDR   <= '0;
         WR_DATA   <= '0;
      end else begin
         WR_EN     <= 1'b0;
         word_done <= 1'b0;

         if (word_done && !addr_full && !period_bad) begin
            WR_EN   <= 1'b1;
            WR_DATA <= sreg;
            WR_ADDR <= addr;
            if (addr == ADDR_W'(LAST_ADDR)) begin
               addr_full <= 1'b1;
            end else begin
               addr <= addr + 1'b1;
            end
         end

         if (frame_restart) begin
            addr      <= '0;
            addr_full <= 1'b0;
         end

         if (period_bad || vs_fall) begin
            sreg  <= '0;
            phase <= '0;
         end else if (in_window) begin
            sreg      <= {sreg[6:0], pix_bit};
            phase     <= phase + 3'd1;
            word_done <= (phase == 3'd7);
         end
      end
   end

endmodule
